// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default geometry and address-width helper for reg_file_sync
package reg_file_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  function automatic int addr_w(input int depth);
    return depth <= 2 ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/reg_word.sv
// reg_word: one storage word with enable, synchronous clear and valid flag
module reg_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (en) begin
      q     <= d;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/reg_file_sync.sv
// reg_file_sync: 1-write 2-read register file with registered reads, valid flags and optional write bypass
module reg_file_sync import reg_file_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int BYPASS = 1,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              werr
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic [WIDTH-1:0] words [DEPTH];
  logic [DEPTH-1:0] valids;
  logic             w_ok, hit0, hit1;
  logic [WIDTH:0]   n0, n1;
  assign w_ok = {1'b0, waddr} < DEPTH_L;
  assign hit0 = we && w_ok && raddr0 == waddr;
  assign hit1 = we && w_ok && raddr1 == waddr;
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk(clk), .rst(rst), .clr(clr),
      .en(we && waddr == ADDR_W'(i)),
      .d(wdata), .q(words[i]), .valid(valids[i])
    );
  end
  // out-of-range read addresses match no word and fall through to zero
  always_comb begin
    n0 = '0;
    n1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr0 == ADDR_W'(i)) n0 = {valids[i], words[i]};
      if (raddr1 == ADDR_W'(i)) n1 = {valids[i], words[i]};
    end
    if (BYPASS != 0 && hit0) n0 = {1'b1, wdata};
    if (BYPASS != 0 && hit1) n1 = {1'b1, wdata};
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      {rvalid0, rdata0} <= '0;
      {rvalid1, rdata1} <= '0;
      werr              <= 1'b0;
    end else begin
      {rvalid0, rdata0} <= n0;
      {rvalid1, rdata1} <= n1;
      werr              <= we && !w_ok;
    end
  end
endmodule

// File: tb/tb_reg_file_sync.sv
// tb_reg_file_sync: four geometries driven by shared random traffic, checked against an array model
module tb_reg_file_sync;
  localparam int WD[4] = '{8, 8, 32, 1};
  localparam int AW[4] = '{3, 3, 4, 1};
  localparam int DP[4] = '{8, 6, 16, 2};
  localparam int BP[4] = '{1, 0, 1, 0};
  logic        clk = 0, rst = 0, clr = 0, we = 0;
  logic [3:0]  waddr = 0, raddr0 = 0, raddr1 = 0;
  logic [31:0] wdata = 0;
  logic [7:0]  a_rd0, a_rd1, b_rd0, b_rd1;
  logic [31:0] c_rd0, c_rd1;
  logic        d_rd0, d_rd1;
  logic        rv0[4], rv1[4], werr[4];
  logic [31:0] x_rd0[4], x_rd1[4];
  logic [31:0] mem[4][16];
  logic        vld[4][16];
  logic [31:0] e_rd0[4], e_rd1[4];
  logic        e_rv0[4], e_rv1[4], e_we[4];
  logic        chk_en = 0;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign x_rd0[0] = 32'(a_rd0);
  assign x_rd1[0] = 32'(a_rd1);
  assign x_rd0[1] = 32'(b_rd0);
  assign x_rd1[1] = 32'(b_rd1);
  assign x_rd0[2] = c_rd0;
  assign x_rd1[2] = c_rd1;
  assign x_rd0[3] = 32'(d_rd0);
  assign x_rd1[3] = 32'(d_rd1);
  reg_file_sync #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
    .raddr0(raddr0[2:0]), .raddr1(raddr1[2:0]), .rdata0(a_rd0), .rdata1(a_rd1),
    .rvalid0(rv0[0]), .rvalid1(rv1[0]), .werr(werr[0]));
  reg_file_sync #(.WIDTH(8), .DEPTH(6), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
    .raddr0(raddr0[2:0]), .raddr1(raddr1[2:0]), .rdata0(b_rd0), .rdata1(b_rd1),
    .rvalid0(rv0[1]), .rvalid1(rv1[1]), .werr(werr[1]));
  reg_file_sync #(.WIDTH(32), .DEPTH(16), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(c_rd0), .rdata1(c_rd1),
    .rvalid0(rv0[2]), .rvalid1(rv1[2]), .werr(werr[2]));
  reg_file_sync #(.WIDTH(1), .DEPTH(2), .BYPASS(0)) u_d (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[0]), .wdata(wdata[0]),
    .raddr0(raddr0[0]), .raddr1(raddr1[0]), .rdata0(d_rd0), .rdata1(d_rd1),
    .rvalid0(rv0[3]), .rvalid1(rv1[3]), .werr(werr[3]));

  task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h", n, k, act, exp);
    end
  endtask

  // a read sees the stored word, or the incoming write when bypass applies
  task automatic model_read(input int k, input int r, input int wa, input logic [31:0] wd,
                            output logic [31:0] d, output logic v);
    d = '0;
    v = 1'b0;
    if (r < DP[k]) begin
      d = mem[k][r];
      v = vld[k][r];
      if (BP[k] != 0 && we && r == wa) begin
        d = wd;
        v = 1'b1;
      end
    end
  endtask

  task automatic step();
    for (int k = 0; k < 4; k++) begin
      int am = (1 << AW[k]) - 1;
      int wa = int'(waddr) & am;
      logic [31:0] wd = wdata & 32'((64'd1 << WD[k]) - 1);
      if (rst || clr) begin
        for (int i = 0; i < 16; i++) begin
          mem[k][i] = '0;
          vld[k][i] = 1'b0;
        end
        {e_rd0[k], e_rv0[k], e_rd1[k], e_rv1[k], e_we[k]} = '0;
      end else begin
        model_read(k, int'(raddr0) & am, wa, wd, e_rd0[k], e_rv0[k]);
        model_read(k, int'(raddr1) & am, wa, wd, e_rd1[k], e_rv1[k]);
        e_we[k] = we && wa >= DP[k];
        if (we && wa < DP[k]) begin
          mem[k][wa] = wd;
          vld[k][wa] = 1'b1;
        end
      end
    end
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input int wa, input logic [31:0] wd, input int r0, input int r1);
    we = w;
    waddr = 4'(wa);
    wdata = wd;
    raddr0 = 4'(r0);
    raddr1 = 4'(r1);
    step();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("rdata0", k, x_rd0[k], e_rd0[k]);
        chk("rvalid0", k, 32'(rv0[k]), 32'(e_rv0[k]));
        chk("rdata1", k, x_rd1[k], e_rd1[k]);
        chk("rvalid1", k, 32'(rv1[k]), 32'(e_rv1[k]));
        chk("werr", k, 32'(werr[k]), 32'(e_we[k]));
      end
    end
  end

  initial begin
    @(negedge clk);
    #1;
    rst = 1;
    drive(1, 3, 32'h55, 3, 3);
    rst = 0;
    chk("lit_reset_rd0", 0, x_rd0[0], 32'h0);
    chk("lit_reset_werr", 0, 32'(werr[0]), 32'h0);
    drive(1, 3, 32'hA5, 0, 0);
    drive(0, 0, 0, 3, 4);
    chk("lit_rd0_a5", 0, x_rd0[0], 32'hA5);
    chk("lit_rv0_a5", 0, 32'(rv0[0]), 32'h1);
    chk("lit_rd1_empty", 0, x_rd1[0], 32'h0);
    chk("lit_rv1_empty", 0, 32'(rv1[0]), 32'h0);
    drive(1, 5, 32'h11, 0, 0);
    drive(1, 5, 32'h3C, 5, 5);
    chk("lit_bypass_on", 0, x_rd0[0], 32'h3C);
    chk("lit_bypass_off", 1, x_rd0[1], 32'h11);
    drive(0, 0, 0, 5, 5);
    chk("lit_reread", 1, x_rd0[1], 32'h3C);
    drive(1, 7, 32'hEE, 0, 0);
    chk("lit_werr_set", 1, 32'(werr[1]), 32'h1);
    drive(0, 0, 0, 6, 5);
    chk("lit_werr_clear", 1, 32'(werr[1]), 32'h0);
    chk("lit_oor_rd", 1, x_rd0[1], 32'h0);
    chk("lit_oor_rv", 1, 32'(rv0[1]), 32'h0);
    chk("lit_unchanged", 1, x_rd1[1], 32'h3C);
    for (int a = 0; a < 16; a++) drive(1, a, 32'hFFFF_FFFF, 0, 0);
    clr = 1;
    drive(1, 2, 32'h5A, 2, 2);
    clr = 0;
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, a, a);
      chk("lit_clr_rd", 0, x_rd0[0], 32'h0);
      chk("lit_clr_rv", 0, 32'(rv1[0]), 32'h0);
    end
    drive(1, 1, 32'h77, 0, 0);
    rst = 1;
    clr = 1;
    drive(1, 1, 32'h99, 1, 1);
    rst = 0;
    clr = 0;
    chk("lit_rst_rd", 0, x_rd0[0], 32'h0);
    chk("lit_rst_rv", 0, 32'(rv0[0]), 32'h0);
    drive(1, 1, 32'h42, 0, 0);
    drive(0, 0, 0, 1, 1);
    chk("lit_post_rst", 0, x_rd0[0], 32'h42);
    chk("lit_post_rst_rv", 0, 32'(rv0[0]), 32'h1);
    for (int n = 0; n < 10000; n++) begin
      rst = $urandom_range(0, 255) == 0;
      clr = $urandom_range(0, 63) == 0;
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    rst = 0;
    clr = 0;
    @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
